// File: rtl/galois_lfsr_pipe_pkg.sv
// Shared constants for the Galois LFSR pipeline.
// Holds the default WIDTH/TAPS/SEED values, a table of maximal-length Galois
// tap masks for widths 2..32, and a helper that sizes the step counter.
// No ports.
package galois_lfsr_pipe_pkg;

   localparam int          DEF_WIDTH = 5;
   localparam logic [31:0] DEF_TAPS  = 32'h0000_0014;
   localparam logic [31:0] DEF_SEED  = 32'h0000_0001;
   localparam int          DEF_DEPTH = 3;
   localparam int          DEF_STEPS = 1;
   localparam int          DEF_CNT_W = 16;

   // Right-shifting Galois masks; bit WIDTH-1 is always set so the zero
   // state can never be entered from a non-zero seed.
   function automatic logic [31:0] max_len_taps(input int width);
      case (width)
         2:       return 32'h0000_0003;
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // A maximal-length sequence has period 2^width-1, which fits in width bits.
   function automatic int cnt_w_for(input int width);
      return (width < 2) ? 2 : width;
   endfunction

endpackage

// File: rtl/galois_lfsr_pipe_if.sv
// Control/status bundle of the Galois LFSR pipeline.
//   en        advance request
//   ld_valid  seed load request, ld_seed the seed
//   state     oldest history stage, state_new newest stage
//   wrap      pulse on return to the active seed, period its last length
//   lockup    pulse when a zero seed was replaced by the default seed
// master drives requests, slave (the LFSR) drives status.
import galois_lfsr_pipe_pkg::*;

interface galois_lfsr_pipe_if #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);
   logic             en;
   logic             ld_valid;
   logic [WIDTH-1:0] ld_seed;
   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] state_new;
   logic             wrap;
   logic [CNT_W-1:0] period;
   logic             lockup;

   modport master (
      output en, ld_valid, ld_seed,
      input  state, state_new, wrap, period, lockup
   );

   modport slave (
      input  en, ld_valid, ld_seed,
      output state, state_new, wrap, period, lockup
   );
endinterface

// File: rtl/galois_lfsr_next.sv
// Combinational next-state function of the Galois LFSR.
// Applies the single step f(s) = (s >> 1) ^ (s[0] ? TAPS : 0) STEPS times.
//   cur  current newest stage
//   nxt  value after STEPS steps
import galois_lfsr_pipe_pkg::*;

module galois_lfsr_next #(
   parameter int               WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS[WIDTH-1:0],
   parameter int               STEPS = DEF_STEPS
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   logic [WIDTH-1:0] s;

   always_comb begin
      s = cur;
      for (int i = 0; i < STEPS; i++) begin
         s = (s >> 1) ^ (s[0] ? TAPS : '0);
      end
      nxt = s;
   end

endmodule

// File: rtl/galois_lfsr_pipe.sv
// Parametrised Galois LFSR with a DEPTH-stage history pipeline, runtime seed
// load with zero-seed rejection, and period measurement.
//   clk   clock, all state on posedge
//   rst   asynchronous active-low reset
//   bus   galois_lfsr_pipe_if.slave (en, ld_valid, ld_seed in;
//         state, state_new, wrap, period, lockup out)
// state/state_new are direct stage taps; every other output is registered.
import galois_lfsr_pipe_pkg::*;

module galois_lfsr_pipe #(
   parameter int               WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS[WIDTH-1:0],
   parameter int               DEPTH = DEF_DEPTH,
   parameter int               STEPS = DEF_STEPS,
   parameter logic [WIDTH-1:0] SEED  = DEF_SEED[WIDTH-1:0],
   parameter int               CNT_W = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   galois_lfsr_pipe_if.slave  bus
);

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("galois_lfsr_pipe: WIDTH must be >= 2");
      end
      if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
         $error("galois_lfsr_pipe: TAPS[WIDTH-1] must be 1");
      end
      if (DEPTH < 1) begin : g_bad_depth
         $error("galois_lfsr_pipe: DEPTH must be >= 1");
      end
      if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
         $error("galois_lfsr_pipe: STEPS must be in 1..WIDTH");
      end
      if (SEED == '0) begin : g_bad_seed
         $error("galois_lfsr_pipe: SEED must be non-zero");
      end
   endgenerate

   logic [WIDTH-1:0] stage [DEPTH];
   logic [WIDTH-1:0] seed_reg;
   logic [WIDTH-1:0] next;
   logic [WIDTH-1:0] load_val;
   logic             load_zero;
   logic [CNT_W-1:0] step_cnt;
   logic [CNT_W-1:0] period_r;
   logic             wrap_r;
   logic             lockup_r;

   galois_lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .STEPS (STEPS)
   ) u_next (
      .cur (stage[DEPTH-1]),
      .nxt (next)
   );

   // A zero seed would lock the register at zero forever; substitute SEED.
   assign load_zero = (bus.ld_seed == '0);
   assign load_val  = load_zero ? SEED : bus.ld_seed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= SEED;
         end
         seed_reg <= SEED;
         step_cnt <= '0;
         period_r <= '0;
         wrap_r   <= 1'b0;
         lockup_r <= 1'b0;
      end else if (bus.ld_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= load_val;
         end
         seed_reg <= load_val;
         step_cnt <= '0;
         wrap_r   <= 1'b0;
         lockup_r <= load_zero;
      end else if (bus.en) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            stage[i] <= stage[i+1];
         end
         stage[DEPTH-1] <= next;
         lockup_r       <= 1'b0;
         if (next == seed_reg) begin
            wrap_r   <= 1'b1;
            period_r <= step_cnt + CNT_W'(1);
            step_cnt <= '0;
         end else begin
            wrap_r   <= 1'b0;
            step_cnt <= step_cnt + CNT_W'(1);
         end
      end else begin
         wrap_r   <= 1'b0;
         lockup_r <= 1'b0;
      end
   end

   assign bus.state     = stage[0];
   assign bus.state_new = stage[DEPTH-1];
   assign bus.wrap      = wrap_r;
   assign bus.period    = period_r;
   assign bus.lockup    = lockup_r;

endmodule

// File: tb/tb_galois_lfsr_pipe.sv
// Bench for galois_lfsr_pipe: a STEPS=1 and a STEPS=2 instance share the same
// stimulus and are compared each cycle against a sequence-level reference.
module tb_galois_lfsr_pipe;

   localparam int W  = 5;
   localparam int CW = 16;
   localparam int D  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   galois_lfsr_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus1 ();
   galois_lfsr_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus2 ();

   galois_lfsr_pipe #(
      .WIDTH(W), .TAPS(5'h14), .DEPTH(D), .STEPS(1), .SEED(5'h01), .CNT_W(CW)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );

   galois_lfsr_pipe #(
      .WIDTH(W), .TAPS(5'h14), .DEPTH(D), .STEPS(2), .SEED(5'h01), .CNT_W(CW)
   ) dut2 (
      .clk(clk), .rst(rst), .bus(bus2.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference: per instance, history of the last D sequence values
   int m_hist [2][D];
   int m_seed [2];
   int m_cnt  [2];
   int m_per  [2];
   int m_wrap [2];
   int m_lock [2];
   int m_steps [2] = '{1, 2};

   function automatic int lfsr_f(input int s);
      return (s / 2) ^ (((s % 2) == 1) ? 'h14 : 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < D; i++) m_hist[k][i] = 1;
         m_seed[k] = 1;
         m_cnt[k]  = 0;
         m_per[k]  = 0;
         m_wrap[k] = 0;
         m_lock[k] = 0;
      end
   endtask

   task automatic model_edge(input bit e, input bit l, input int sd);
      int v;
      for (int k = 0; k < 2; k++) begin
         if (l) begin
            v = (sd == 0) ? 1 : sd;
            for (int i = 0; i < D; i++) m_hist[k][i] = v;
            m_seed[k] = v;
            m_cnt[k]  = 0;
            m_wrap[k] = 0;
            m_lock[k] = (sd == 0) ? 1 : 0;
         end else if (e) begin
            v = m_hist[k][D-1];
            for (int j = 0; j < m_steps[k]; j++) v = lfsr_f(v);
            for (int i = 0; i < D - 1; i++) m_hist[k][i] = m_hist[k][i+1];
            m_hist[k][D-1] = v;
            m_lock[k] = 0;
            if (v == m_seed[k]) begin
               m_wrap[k] = 1;
               m_per[k]  = (m_cnt[k] + 1) % (1 << CW);
               m_cnt[k]  = 0;
            end else begin
               m_wrap[k] = 0;
               m_cnt[k]  = (m_cnt[k] + 1) % (1 << CW);
            end
         end else begin
            m_wrap[k] = 0;
            m_lock[k] = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("s1_state",     bus1.state,     m_hist[0][0]);
      chk("s1_state_new", bus1.state_new, m_hist[0][D-1]);
      chk("s1_wrap",      bus1.wrap,      m_wrap[0]);
      chk("s1_period",    bus1.period,    m_per[0]);
      chk("s1_lockup",    bus1.lockup,    m_lock[0]);
      chk("s2_state",     bus2.state,     m_hist[1][0]);
      chk("s2_state_new", bus2.state_new, m_hist[1][D-1]);
      chk("s2_wrap",      bus2.wrap,      m_wrap[1]);
      chk("s2_period",    bus2.period,    m_per[1]);
      chk("s2_lockup",    bus2.lockup,    m_lock[1]);
   endtask

   task automatic drive(input bit e, input bit l, input int sd);
      logic [W-1:0] s5;
      s5 = sd[W-1:0];
      bus1.en = e; bus1.ld_valid = l; bus1.ld_seed = s5;
      bus2.en = e; bus2.ld_valid = l; bus2.ld_seed = s5;
      @(posedge clk);
      #1;
      model_edge(e, l, int'(s5));
      check_all();
   endtask

   // advance until the STEPS=1 instance wraps; returns advances taken
   task automatic run_to_wrap(input string tag, output int n);
      n = 0;
      do begin
         drive(1'b1, 1'b0, 0);
         n++;
      end while (bus1.wrap !== 1'b1 && n < 100);
      if (n >= 100) chk({tag, "_timeout"}, 32'(n), 32'd31);
   endtask

   task automatic async_reset();
      #3 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_period", bus1.period, 32'd0);
      #1 rst = 1'b1;
   endtask

   int exp_new [3];
   int exp_old [3];
   int exp_s2  [2];
   int n;
   int r;
   int sd;

   initial begin
      bus1.en = 1'b0; bus1.ld_valid = 1'b0; bus1.ld_seed = '0;
      bus2.en = 1'b0; bus2.ld_valid = 1'b0; bus2.ld_seed = '0;
      model_reset();
      #12;
      check_all();
      chk("rst_state_new", bus1.state_new, 32'h01);
      rst = 1'b1;

      // first three advances from reset
      exp_new = '{'h14, 'h0A, 'h05};
      exp_old = '{'h01, 'h01, 'h14};
      exp_s2  = '{'h0A, 'h16};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 0);
         chk("dir_state_new", bus1.state_new, exp_new[i]);
         chk("dir_state",     bus1.state,     exp_old[i]);
         if (i < 2) chk("dir_s2_state_new", bus2.state_new, exp_s2[i]);
      end

      // hold
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 0);
         chk("hold_state_new", bus1.state_new, 32'h05);
         chk("hold_state",     bus1.state,     32'h14);
      end

      // zero seed rejected
      drive(1'b0, 1'b1, 0);
      chk("zero_lockup", bus1.lockup,    32'd1);
      chk("zero_state",  bus1.state,     32'h01);
      chk("zero_new",    bus1.state_new, 32'h01);
      drive(1'b0, 1'b0, 0);
      chk("zero_lockup_clr", bus1.lockup, 32'd0);

      // explicit seed load then one advance
      drive(1'b0, 1'b1, 'h16);
      chk("ld16_state",     bus1.state,     32'h16);
      chk("ld16_state_new", bus1.state_new, 32'h16);
      drive(1'b1, 1'b0, 0);

      // load wins over en
      drive(1'b1, 1'b1, 'h05);
      chk("ld_en_state",     bus1.state,     32'h05);
      chk("ld_en_state_new", bus1.state_new, 32'h05);
      run_to_wrap("wrap_ld", n);
      chk("wrap_ld_advances", 32'(n), 32'd31);
      chk("wrap_ld_period",   bus1.period, 32'd31);
      chk("wrap_ld_new",      bus1.state_new, 32'h05);

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 15);
         sd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
         drive($urandom_range(0, 3) != 0, r == 0, sd);
      end

      // wrap cadence from reset, then async reset drops the period
      async_reset();
      run_to_wrap("wrap_rst1", n);
      chk("wrap_rst1_advances", 32'(n), 32'd31);
      chk("wrap_rst1_new",      bus1.state_new, 32'h01);
      chk("wrap_rst1_period",   bus1.period, 32'd31);
      run_to_wrap("wrap_rst2", n);
      chk("wrap_rst2_advances", 32'(n), 32'd31);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 0);
      chk("pre_async_period", bus1.period, 32'd31);
      async_reset();
      drive(1'b1, 1'b0, 0);
      chk("post_async_new", bus1.state_new, 32'h14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
